carregador_matrizes: RTL and testbench

CARREGADOR_MATRIZES -- requirements
Module: carregador_matrizes

---
 rtl/carregador_matrizes_pkg.sv | 28 ++
 rtl/carregador_matrizes_registrador.sv | 54 +++++
 rtl/carregador_matrizes.sv | 171 +++++++++++++++++
 tb/tb_carregador_matrizes.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carregador_matrizes_pkg.sv
`default_nettype none
// ============================================================================
// Package    : pacote_matrizes
// File       : carregador_matrizes_pkg.sv
// Description: Shared constants and state type for the 5x5 matrix loader.
//              TAM_ELEM    - element width in bits (signed two's complement)
//              N_ELEM      - elements per matrix (5x5)
//              LARG_MATRIZ - width of one flattened matrix (200 bits)
//              estado_t    - loader state enumeration
// Revision   : 1.0 - initial release
// ============================================================================
package pacote_matrizes;

  localparam int TAM_ELEM    = 8;
  localparam int N_ELEM      = 25;
  localparam int LARG_MATRIZ = TAM_ELEM * N_ELEM;

  // Explicit 2-bit encoding so the state register width never depends on
  // tool defaults.
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARGA_A = 2'd1,
    CARGA_B = 2'd2,
    PRONTO  = 2'd3
  } estado_t;

endpackage : pacote_matrizes
`default_nettype wire

// File: rtl/carregador_matrizes_registrador.sv
`default_nettype none
// ============================================================================
// Module     : registrador_matriz
// File       : carregador_matrizes_registrador.sv
// Description: N_ELEM x TAM_ELEM storage for one flattened matrix. One element
//              is written per cycle at the index given; a synchronous clear
//              zeroes the whole matrix and takes priority over the write.
// Ports      : clock      - rising-edge clock
//              reset      - asynchronous active-high reset (clears storage)
//              limpar_i   - synchronous clear of every element
//              escrever_i - write enable for element indice_i
//              indice_i   - element index k (0..N_ELEM-1)
//              dado_i     - element value to write
//              matriz_o   - flattened matrix, element k at [TAM_ELEM*k +: TAM_ELEM]
// Revision   : 1.0 - initial release
// ============================================================================
module registrador_matriz #(
  parameter int TAM_ELEM = pacote_matrizes::TAM_ELEM,
  parameter int N_ELEM   = pacote_matrizes::N_ELEM,
  parameter int LARG_IND = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         limpar_i,
  input  logic                         escrever_i,
  input  logic [LARG_IND-1:0]          indice_i,
  input  logic [TAM_ELEM-1:0]          dado_i,
  output logic [TAM_ELEM*N_ELEM-1:0]   matriz_o
);

  import pacote_matrizes::*;

  logic [TAM_ELEM*N_ELEM-1:0] matriz_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      matriz_q <= '0;
    end else if (limpar_i) begin
      matriz_q <= '0;
    end else if (escrever_i) begin
      // Decoded write: each element slice compares its own index, which keeps
      // the part-select offsets constant after unrolling.
      for (int k = 0; k < N_ELEM; k++) begin
        if (indice_i == LARG_IND'(k)) begin
          matriz_q[k*TAM_ELEM +: TAM_ELEM] <= dado_i;
        end
      end
    end
  end

  assign matriz_o = matriz_q;

endmodule : registrador_matriz
`default_nettype wire

// File: rtl/carregador_matrizes.sv
`default_nettype none
// ============================================================================
// Module     : carregador_matrizes
// File       : carregador_matrizes.sv
// Description: Streams two signed 5x5 matrices (A then B) into flattened
//              registers for a downstream adder stage. Element index
//              k = linha + 5*coluna, streamed in order k = 0..24 for A, then
//              immediately k = 0..24 for B. Both matrices are presented as
//              valid and stable until the consumer acknowledges them.
// Ports      : clock             - rising-edge clock
//              reset             - asynchronous active-high reset
//              abortar           - (optional) return to OCIOSO and clear data
//              iniciar           - start request, sampled only in OCIOSO
//              dado              - incoming signed element
//              dado_valido       - dado holds a valid element
//              dado_pronto       - block accepts dado this cycle
//              matriz_a/matriz_b - flattened matrices A and B
//              matrizes_validas  - both matrices complete and stable
//              consumidor_pronto - consumer has taken the matrices
//              ocupado           - high in every state except OCIOSO
// Config     : CARREGADOR_MATRIZES_ABORTAR_EN - adds the abortar input
// Revision   : 1.0 - initial release
// ============================================================================
module carregador_matrizes #(
  parameter int TAM_ELEM = pacote_matrizes::TAM_ELEM,
  parameter int N_ELEM   = pacote_matrizes::N_ELEM
) (
  input  logic                         clock,
  input  logic                         reset,
`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
  input  logic                         abortar,
`endif
  input  logic                         iniciar,
  input  logic signed [TAM_ELEM-1:0]   dado,
  input  logic                         dado_valido,
  output logic                         dado_pronto,
  output logic [TAM_ELEM*N_ELEM-1:0]   matriz_a,
  output logic [TAM_ELEM*N_ELEM-1:0]   matriz_b,
  output logic                         matrizes_validas,
  input  logic                         consumidor_pronto,
  output logic                         ocupado
);

  import pacote_matrizes::*;

  localparam int                  LARG_CONT = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [LARG_CONT-1:0] ULTIMO   = LARG_CONT'(N_ELEM - 1);

  estado_t               estado_q, estado_d;
  logic [LARG_CONT-1:0]  cont_q, cont_d;

  logic w_transf;
  logic w_limpar;
  logic w_escreve_a;
  logic w_escreve_b;

  // Outputs are decoded straight from the state register, so the reset
  // values follow the asynchronous state reset with no extra flops, and
  // matrizes_validas rises the cycle after the last B transfer.
  assign dado_pronto      = (estado_q == CARGA_A) || (estado_q == CARGA_B);
  assign ocupado          = (estado_q != OCIOSO);
  assign matrizes_validas = (estado_q == PRONTO);

  assign w_transf = dado_valido && dado_pronto;

  always_comb begin
    estado_d    = estado_q;
    cont_d      = cont_q;
    w_limpar    = 1'b0;
    w_escreve_a = 1'b0;
    w_escreve_b = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          estado_d = CARGA_A;
          cont_d   = '0;
          w_limpar = 1'b1;
        end
      end

      CARGA_A: begin
        if (w_transf) begin
          w_escreve_a = 1'b1;
          if (cont_q == ULTIMO) begin
            // Last element of A: B starts on the very next cycle.
            estado_d = CARGA_B;
            cont_d   = '0;
          end else begin
            cont_d = cont_q + 1'b1;
          end
        end
      end

      CARGA_B: begin
        if (w_transf) begin
          w_escreve_b = 1'b1;
          if (cont_q == ULTIMO) begin
            estado_d = PRONTO;
            cont_d   = '0;
          end else begin
            cont_d = cont_q + 1'b1;
          end
        end
      end

      PRONTO: begin
        if (consumidor_pronto) begin
          estado_d = OCIOSO;
        end
      end

      default: begin
        estado_d = OCIOSO;
        cont_d   = '0;
      end
    endcase

`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
    // Abort overrides everything decided above, including a write that
    // would otherwise land on this same edge.
    if (abortar) begin
      estado_d    = OCIOSO;
      cont_d      = '0;
      w_limpar    = 1'b1;
      w_escreve_a = 1'b0;
      w_escreve_b = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
    end
  end

  registrador_matriz #(
    .TAM_ELEM (TAM_ELEM),
    .N_ELEM   (N_ELEM),
    .LARG_IND (LARG_CONT)
  ) u_reg_a (
    .clock      (clock),
    .reset      (reset),
    .limpar_i   (w_limpar),
    .escrever_i (w_escreve_a),
    .indice_i   (cont_q),
    .dado_i     (dado),
    .matriz_o   (matriz_a)
  );

  registrador_matriz #(
    .TAM_ELEM (TAM_ELEM),
    .N_ELEM   (N_ELEM),
    .LARG_IND (LARG_CONT)
  ) u_reg_b (
    .clock      (clock),
    .reset      (reset),
    .limpar_i   (w_limpar),
    .escrever_i (w_escreve_b),
    .indice_i   (cont_q),
    .dado_i     (dado),
    .matriz_o   (matriz_b)
  );

endmodule : carregador_matrizes
`default_nettype wire

// File: tb/tb_carregador_matrizes.sv
`default_nettype none
// ============================================================================
// Module     : tb_carregador_matrizes
// File       : tb_carregador_matrizes.sv
// Description: Self-checking bench for carregador_matrizes. A transfer-count
//              reference model (matrices as plain arrays) is compared against
//              the DUT every cycle; a control table and directed sequences
//              cover start, stalls, hold in PRONTO, reset and abort.
// Config     : CARREGADOR_MATRIZES_ABORTAR_EN - enables the abort sequence
// Revision   : 1.0 - initial release
// ============================================================================
module tb_carregador_matrizes;

  localparam int TE = 8;
  localparam int NE = 25;
  localparam int W  = TE * NE;

  logic                 clock;
  logic                 reset;
  logic                 iniciar;
  logic signed [TE-1:0] dado;
  logic                 dado_valido;
  logic                 dado_pronto;
  logic [W-1:0]         matriz_a;
  logic [W-1:0]         matriz_b;
  logic                 matrizes_validas;
  logic                 consumidor_pronto;
  logic                 ocupado;
`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
  logic                 abortar;
`endif

  carregador_matrizes #(.TAM_ELEM(TE), .N_ELEM(NE)) dut (
    .clock             (clock),
    .reset             (reset),
`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
    .abortar           (abortar),
`endif
    .iniciar           (iniciar),
    .dado              (dado),
    .dado_valido       (dado_valido),
    .dado_pronto       (dado_pronto),
    .matriz_a          (matriz_a),
    .matriz_b          (matriz_b),
    .matrizes_validas  (matrizes_validas),
    .consumidor_pronto (consumidor_pronto),
    .ocupado           (ocupado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: a load is just "transfers seen since start";
  // transfer n goes to A[n] for n < 25 and to B[n-25] otherwise.
  logic [TE-1:0] ma [NE];
  logic [TE-1:0] mb [NE];
  bit            m_carregando;
  bit            m_pronto;
  int            m_n;

  task automatic chk(input string nome, input logic [W-1:0] obtido, input logic [W-1:0] esperado);
    total++;
    if (obtido !== esperado) begin
      bad++;
      $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", nome, obtido, esperado, $time);
    end
  endtask

  task automatic modelo_limpa();
    for (int k = 0; k < NE; k++) begin
      ma[k] = '0;
      mb[k] = '0;
    end
    m_carregando = 1'b0;
    m_pronto     = 1'b0;
    m_n          = 0;
  endtask

  task automatic modelo_passo();
    if (reset) begin
      modelo_limpa();
    end
`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
    else if (abortar) begin
      modelo_limpa();
    end
`endif
    else if (m_carregando) begin
      if (dado_valido) begin
        if (m_n < NE) ma[m_n] = dado;
        else          mb[m_n-NE] = dado;
        m_n++;
        if (m_n == 2*NE) begin
          m_carregando = 1'b0;
          m_pronto     = 1'b1;
        end
      end
    end else if (m_pronto) begin
      if (consumidor_pronto) m_pronto = 1'b0;
    end else if (iniciar) begin
      modelo_limpa();
      m_carregando = 1'b1;
    end
  endtask

  function automatic logic [W-1:0] empacota(input bit sel_b);
    logic [W-1:0] v;
    for (int k = 0; k < NE; k++) v[k*TE +: TE] = sel_b ? mb[k] : ma[k];
    return v;
  endfunction

  task automatic verifica_modelo();
    chk("dado_pronto", W'(dado_pronto), W'(m_carregando));
    chk("ocupado", W'(ocupado), W'(m_carregando || m_pronto));
    chk("matrizes_validas", W'(matrizes_validas), W'(m_pronto));
    chk("matriz_a", matriz_a, empacota(1'b0));
    chk("matriz_b", matriz_b, empacota(1'b1));
  endtask

  // One clock: model sees the inputs at the active edge, outputs are
  // compared on the falling edge, and the caller drives the next inputs.
  task automatic ciclo();
    @(posedge clock);
    modelo_passo();
    @(negedge clock);
    verifica_modelo();
  endtask

  task automatic chk_zeros(input string nome);
    chk({nome, "_dado_pronto"}, W'(dado_pronto), '0);
    chk({nome, "_ocupado"}, W'(ocupado), '0);
    chk({nome, "_validas"}, W'(matrizes_validas), '0);
    chk({nome, "_matriz_a"}, matriz_a, '0);
    chk({nome, "_matriz_b"}, matriz_b, '0);
  endtask

  // Reset asserted mid-cycle: outputs must clear without a clock edge.
  task automatic aplica_reset(input string nome);
    reset = 1'b1;
    #1;
    chk_zeros(nome);
    ciclo();
    reset = 1'b0;
    ciclo();
  endtask

  function automatic logic [TE-1:0] valor(input int i);
    int v;
    v = (i < NE) ? (i + 1) : -(i - NE + 1);
    return v[TE-1:0];
  endfunction

  task automatic inicia();
    iniciar = 1'b1;
    ciclo();
    iniciar = 1'b0;
  endtask

  task automatic carregar(input int de, input int ate, input bit lacuna);
    for (int i = de; i < ate; i++) begin
      if (lacuna) begin
        dado_valido = 1'b0;
        dado        = TE'($urandom);
        ciclo();
      end
      dado_valido = 1'b1;
      dado        = valor(i);
      ciclo();
    end
    dado_valido = 1'b0;
  endtask

  task automatic chk_carga_completa(input string nome);
    chk({nome, "_validas"}, W'(matrizes_validas), W'(1'b1));
    chk({nome, "_a0"}, W'(matriz_a[7:0]), W'(8'h01));
    chk({nome, "_a24"}, W'(matriz_a[199:192]), W'(8'h19));
    chk({nome, "_b0"}, W'(matriz_b[7:0]), W'(8'hFF));
    chk({nome, "_b24"}, W'(matriz_b[199:192]), W'(8'hE7));
  endtask

  typedef struct {
    bit            ini;
    bit            val;
    bit            cons;
    logic [TE-1:0] d;
    bit            e_pronto;
    bit            e_ocup;
    bit            e_valid;
    logic [TE-1:0] e_a0;
    logic [TE-1:0] e_a1;
  } vetor_t;

  vetor_t tabela [7];

  initial begin
    // Control-path table, applied from OCIOSO right after reset.
    tabela[0] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tabela[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tabela[2] = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
    tabela[3] = '{1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00};
    tabela[4] = '{1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00};
    tabela[5] = '{1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00};
    tabela[6] = '{1'b1, 1'b1, 1'b0, 8'hFB, 1'b1, 1'b1, 1'b0, 8'h05, 8'hFB};

    reset             = 1'b1;
    iniciar           = 1'b0;
    dado              = '0;
    dado_valido       = 1'b0;
    consumidor_pronto = 1'b0;
`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
    abortar           = 1'b0;
`endif
    modelo_limpa();
    @(negedge clock);
    ciclo();
    ciclo();
    reset = 1'b0;
    ciclo();
    chk_zeros("reset_inicial");

    for (int i = 0; i < 7; i++) begin
      iniciar           = tabela[i].ini;
      dado_valido       = tabela[i].val;
      consumidor_pronto = tabela[i].cons;
      dado              = tabela[i].d;
      ciclo();
      chk($sformatf("tab%0d_pronto", i), W'(dado_pronto), W'(tabela[i].e_pronto));
      chk($sformatf("tab%0d_ocupado", i), W'(ocupado), W'(tabela[i].e_ocup));
      chk($sformatf("tab%0d_validas", i), W'(matrizes_validas), W'(tabela[i].e_valid));
      chk($sformatf("tab%0d_a0", i), W'(matriz_a[7:0]), W'(tabela[i].e_a0));
      chk($sformatf("tab%0d_a1", i), W'(matriz_a[15:8]), W'(tabela[i].e_a1));
    end
    iniciar           = 1'b0;
    dado_valido       = 1'b0;
    consumidor_pronto = 1'b0;

    // Partial load in progress: reset must wipe it immediately.
    aplica_reset("reset_parcial");

    // Continuous stream A = 1..25, B = -1..-25.
    inicia();
    carregar(0, 2*NE-1, 1'b0);
    chk("continuo_validas_antes", W'(matrizes_validas), '0);
    carregar(2*NE-1, 2*NE, 1'b0);
    chk_carga_completa("continuo");

    // PRONTO holds against iniciar and idle consumer.
    for (int c = 0; c < 10; c++) begin
      iniciar = (c == 4);
      ciclo();
      chk($sformatf("retem%0d_validas", c), W'(matrizes_validas), W'(1'b1));
    end
    iniciar = 1'b0;
    chk_carga_completa("retem");
    consumidor_pronto = 1'b1;
    ciclo();
    consumidor_pronto = 1'b0;
    chk("consumido_validas", W'(matrizes_validas), '0);
    chk("consumido_ocupado", W'(ocupado), '0);
    repeat (3) ciclo();
    chk("ocioso_retem_a24", W'(matriz_a[199:192]), W'(8'h19));

    // Same stream with a bubble before every element.
    inicia();
    chk("nova_carga_limpa_a", matriz_a, '0);
    carregar(0, 2*NE, 1'b1);
    chk_carga_completa("lacunas");
    consumidor_pronto = 1'b1;
    ciclo();
    consumidor_pronto = 1'b0;

    // Reset after 30 transfers, then a clean reload.
    inicia();
    carregar(0, 30, 1'b0);
    aplica_reset("reset_30");
    inicia();
    carregar(0, 2*NE, 1'b0);
    chk_carga_completa("pos_reset");
    consumidor_pronto = 1'b1;
    ciclo();
    consumidor_pronto = 1'b0;

`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
    // Abort coincident with the 12th transfer of A.
    inicia();
    carregar(0, 11, 1'b0);
    abortar     = 1'b1;
    dado_valido = 1'b1;
    dado        = valor(11);
    ciclo();
    abortar     = 1'b0;
    dado_valido = 1'b0;
    chk("abortar_ocupado", W'(ocupado), '0);
    chk("abortar_matriz_a", matriz_a, '0);
    chk("abortar_dado_pronto", W'(dado_pronto), '0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset             = ($urandom_range(0, 299) == 0);
      iniciar           = ($urandom_range(0, 3) == 0);
      dado_valido       = ($urandom_range(0, 3) != 0);
      consumidor_pronto = ($urandom_range(0, 7) == 0);
      dado              = TE'($urandom);
`ifdef CARREGADOR_MATRIZES_ABORTAR_EN
      abortar           = ($urandom_range(0, 149) == 0);
`endif
      ciclo();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_carregador_matrizes
`default_nettype wire
